// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX-stage branch/JALR resolution, mispredict redirect, predictor update and branch statistics
module branch_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic             ex_is_branch,
    input  logic             ex_is_jalr,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    output logic             flush,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_pc,
    input  logic             redir_ready,
    output logic             upd_valid,
    output logic [XLEN-1:0]  upd_addr,
    output logic             upd_taken,
    input  logic             stat_clear,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispred
);

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t            state;
    state_t            state_next;
    logic              resolve;
    logic              is_br;
    logic              taken;
    logic              mispredict;
    logic [XLEN-1:0]   jalr_sum;
    logic [XLEN-1:0]   correct_pc;

    assign ex_ready = (state == IDLE);

    always_comb begin
        is_br    = ex_is_branch & ~ex_is_jalr;
        resolve  = ex_valid & ex_ready & (ex_is_branch | ex_is_jalr);
        jalr_sum = ex_rs1 + ex_imm;
        case (ex_funct3)
            3'b000:  taken = (ex_rs1 == ex_rs2);
            3'b001:  taken = (ex_rs1 != ex_rs2);
            3'b100:  taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  taken = (ex_rs1 <  ex_rs2);
            3'b111:  taken = (ex_rs1 >= ex_rs2);
            default: taken = 1'b0;
        endcase
        // No target predictor exists, so every JALR is treated as a mispredict.
        mispredict = ex_is_jalr | (taken != ex_pred_taken);
        if (ex_is_jalr)
            correct_pc = {jalr_sum[XLEN-1:1], 1'b0};
        else if (taken)
            correct_pc = ex_pc + ex_imm;
        else
            correct_pc = ex_pc + XLEN'(4);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (resolve && mispredict) state_next = REDIRECT;
            REDIRECT: if (redir_ready)           state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            flush       <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            upd_valid   <= 1'b0;
            upd_addr    <= '0;
            upd_taken   <= 1'b0;
        end else begin
            state       <= state_next;
            flush       <= resolve & mispredict;
            redir_valid <= (state_next == REDIRECT);
            if (state == IDLE && state_next == REDIRECT)
                redir_pc <= correct_pc;
            upd_valid   <= resolve & is_br;
            if (resolve && is_br) begin
                upd_addr  <= ex_pc;
                upd_taken <= taken;
            end
        end
    end

    // Saturating statistics; a clear wins over an increment in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (stat_clear) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (resolve && is_br) begin
            if (stat_branches != {CNT_W{1'b1}})
                stat_branches <= stat_branches + CNT_W'(1);
            if (mispredict && stat_mispred != {CNT_W{1'b1}})
                stat_mispred <= stat_mispred + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed and randomized checks of branch_resolve against a behavioural model
module tb_branch_resolve;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jalr;
    logic [31:0] ex_pc;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_imm;
    logic        ex_pred_taken;
    logic        redir_ready;
    logic        stat_clear;

    logic        ex_ready, flush, redir_valid, upd_valid, upd_taken;
    logic [31:0] redir_pc, upd_addr;
    logic [15:0] stat_branches, stat_mispred;

    logic        ex_ready2, flush2, redir_valid2, upd_valid2, upd_taken2;
    logic [31:0] redir_pc2, upd_addr2;
    logic [1:0]  stat_branches2, stat_mispred2;

    int n_assert = 0;
    int n_fail   = 0;

    logic        m_redir;
    logic        e_flush, e_uvalid, e_utaken;
    logic [31:0] e_pc, e_uaddr;
    int          b16, m16, b2, m2;

    branch_resolve #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_branch(ex_is_branch), .ex_is_jalr(ex_is_jalr), .ex_pc(ex_pc),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken), .flush(flush), .redir_valid(redir_valid),
        .redir_pc(redir_pc), .redir_ready(redir_ready), .upd_valid(upd_valid),
        .upd_addr(upd_addr), .upd_taken(upd_taken), .stat_clear(stat_clear),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    branch_resolve #(.XLEN(32), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready2),
        .ex_is_branch(ex_is_branch), .ex_is_jalr(ex_is_jalr), .ex_pc(ex_pc),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken), .flush(flush2), .redir_valid(redir_valid2),
        .redir_pc(redir_pc2), .redir_ready(redir_ready), .upd_valid(upd_valid2),
        .upd_addr(upd_addr2), .upd_taken(upd_taken2), .stat_clear(stat_clear),
        .stat_branches(stat_branches2), .stat_mispred(stat_mispred2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_redir  = 1'b0;
        e_flush  = 1'b0;
        e_uvalid = 1'b0;
        e_utaken = 1'b0;
        e_pc     = 32'h0;
        e_uaddr  = 32'h0;
        b16 = 0; m16 = 0; b2 = 0; m2 = 0;
    endtask

    task automatic check_outputs();
        chk("ex_ready", {31'b0, ex_ready}, {31'b0, !m_redir});
        chk("flush", {31'b0, flush}, {31'b0, e_flush});
        chk("redir_valid", {31'b0, redir_valid}, {31'b0, m_redir});
        if (m_redir) chk("redir_pc", redir_pc, e_pc);
        chk("upd_valid", {31'b0, upd_valid}, {31'b0, e_uvalid});
        chk("upd_addr", upd_addr, e_uaddr);
        chk("upd_taken", {31'b0, upd_taken}, {31'b0, e_utaken});
        chk("stat_branches", {16'b0, stat_branches}, b16);
        chk("stat_mispred", {16'b0, stat_mispred}, m16);
        chk("stat_branches_w2", {30'b0, stat_branches2}, b2);
        chk("stat_mispred_w2", {30'b0, stat_mispred2}, m2);
        chk("redir_valid_w2", {31'b0, redir_valid2}, {31'b0, m_redir});
    endtask

    // Advance one clock, predicting the architectural effect of the inputs now applied.
    task automatic cycle();
        logic        fire, br, tk, mis;
        logic [31:0] npc, jt;
        chk("ex_ready_pre", {31'b0, ex_ready}, {31'b0, !m_redir});
        br   = ex_is_branch && !ex_is_jalr;
        tk   = ref_taken(ex_funct3, ex_rs1, ex_rs2);
        jt   = ex_rs1 + ex_imm;
        jt[0] = 1'b0;
        mis  = ex_is_jalr ? 1'b1 : (tk != ex_pred_taken);
        npc  = ex_is_jalr ? jt : (tk ? ex_pc + ex_imm : ex_pc + 32'd4);
        fire = !m_redir && ex_valid && (ex_is_branch || ex_is_jalr);
        e_flush  = fire && mis;
        e_uvalid = fire && br;
        if (fire && br) begin
            e_uaddr  = ex_pc;
            e_utaken = tk;
        end
        if (stat_clear) begin
            b16 = 0; m16 = 0; b2 = 0; m2 = 0;
        end else if (fire && br) begin
            if (b16 < 65535) b16++;
            if (b2 < 3) b2++;
            if (mis && m16 < 65535) m16++;
            if (mis && m2 < 3) m2++;
        end
        if (m_redir) begin
            if (redir_ready) m_redir = 1'b0;
        end else if (fire && mis) begin
            m_redir = 1'b1;
            e_pc    = npc;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic br, input logic jalr, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm, input logic pred);
        ex_valid = 1'b1; ex_is_branch = br; ex_is_jalr = jalr; ex_pc = pc; ex_funct3 = f3;
        ex_rs1 = a; ex_rs2 = b; ex_imm = imm; ex_pred_taken = pred;
    endtask

    task automatic idle(input logic rdy);
        ex_valid = 1'b0; redir_ready = rdy; stat_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stat_clear = 1'b0; redir_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        ex_valid = 1'b0;
        model_reset();
        #2;
        check_outputs();
        chk("reset_redir_pc", redir_pc, 32'h0);
        #10;
        reset = 1'b0;

        // BEQ correctly predicted taken
        drive(1'b1, 1'b0, 32'h100, 3'd0, 32'd5, 32'd5, 32'h20, 1'b1);
        cycle();
        idle(1'b0); cycle();

        // BLT signed, predicted not taken -> mispredict, ack after one wait cycle
        drive(1'b1, 1'b0, 32'h300, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0);
        redir_ready = 1'b1;
        cycle();
        idle(1'b0); cycle();
        idle(1'b1); cycle();
        idle(1'b0); cycle();

        // BLTU not taken but predicted taken, held three cycles before ack
        drive(1'b1, 1'b0, 32'h200, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1);
        cycle();
        ex_pred_taken = 1'b0; redir_ready = 1'b0;
        repeat (3) cycle();
        idle(1'b1); cycle();
        idle(1'b0); cycle();

        // JALR with odd target bit cleared
        drive(1'b0, 1'b1, 32'h400, 3'd0, 32'h1001, 32'h0, 32'h2, 1'b0);
        cycle();
        idle(1'b1); cycle();

        // Saturation of the narrow counters
        idle(1'b0); stat_clear = 1'b1; cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h500 + 32'(i * 8), 3'd1, 32'd7, 32'd7, 32'h10, 1'b1);
            cycle();
            idle(1'b1); cycle();
        end
        drive(1'b1, 1'b0, 32'h600, 3'd0, 32'd9, 32'd9, 32'h10, 1'b1);
        stat_clear = 1'b1;
        cycle();
        idle(1'b0); cycle();

        // Asynchronous reset while redirect pending
        drive(1'b1, 1'b0, 32'h700, 3'd5, 32'd3, 32'd3, 32'h8, 1'b0);
        cycle();
        #1 reset = 1'b1;
        #1;
        chk("async_redir_valid", {31'b0, redir_valid}, 32'h0);
        chk("async_flush", {31'b0, flush}, 32'h0);
        chk("async_ex_ready", {31'b0, ex_ready}, 32'h1);
        model_reset();
        idle(1'b0);
        #4 reset = 1'b0;
        @(posedge clk); #1;
        check_outputs();

        for (int i = 0; i < 600; i++) begin
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_is_branch  = $urandom_range(0, 1);
            ex_is_jalr    = ($urandom_range(0, 3) == 0);
            ex_funct3     = 3'($urandom_range(0, 7));
            ex_pc         = {$urandom} & 32'hFFFF_FFFC;
            ex_rs1        = $urandom;
            ex_rs2        = ($urandom_range(0, 3) == 0) ? ex_rs1 : $urandom;
            ex_imm        = $urandom;
            ex_pred_taken = $urandom_range(0, 1);
            redir_ready   = $urandom_range(0, 1);
            stat_clear    = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
